// File: rtl/prog_bank_ctrl.sv
// prog_bank_ctrl: P-ROM bank controller. Synchronises the 68K port write
// strobe, commits P2 bank writes, runs the game-select unlock sequence with
// a settle window, and forms the flash address and per-chip enables.
module prog_bank_ctrl #(
  parameter int          CHIPS       = 3,
  parameter int          CSEL_W      = 2,
  parameter int          CHIP_AW     = 26,
  parameter int          BANK_W      = 3,
  parameter int          SYNC_STAGES = 2,
  parameter int          SETTLE      = 4,
  parameter int          UNLOCK_TO   = 255,
  parameter logic [18:0] GSEL_ADDR   = 19'h607F7,
  localparam int         IX_W        = CHIP_AW + CSEL_W - 19
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [19:1]       M68K_ADDR,
  input  logic [15:0]       M68K_DATA,
  input  logic              nPORTWEL,
  input  logic              nPORTOEL,
  input  logic              nPORTOEU,
  input  logic              nROMOE,
  input  logic [IX_W-1:0]   TBL_IX,
  input  logic [BANK_W-1:0] TBL_BANKS,
  output logic [CHIP_AW-1:0] P_ADDR,
  output logic [CHIPS-1:0]  P_nCE,
  output logic              P_nOE,
  output logic [7:0]        GSEL,
  output logic [BANK_W-1:0] P_BANK,
  output logic              BUSY
);

  localparam int HI_W = CHIP_AW - 19;
  localparam int TO_W = (UNLOCK_TO < 1) ? 1 : $clog2(UNLOCK_TO + 1);
  localparam int ST_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, K1, K2} unlock_t;

  logic [SYNC_STAGES-1:0] we_sync;
  logic                   we_prev;
  logic                   we_s;
  logic                   we_fall;
  logic                   we_rise;
  logic [18:0]            hold_addr;
  logic [7:0]             hold_data;
  logic                   is_gsel;
  logic                   gsel_commit;
  logic                   bank_commit;
  unlock_t                state_r;
  unlock_t                state_n;
  logic                   gsel_load;
  logic [TO_W-1:0]        to_cnt;
  logic [ST_W-1:0]        busy_cnt;
  logic [IX_W-1:0]        ix_r;
  logic [BANK_W-1:0]      banks_r;
  logic [IX_W-1:0]        offset;
  logic [IX_W-1:0]        sum;
  logic [CSEL_W-1:0]      csel;
  logic                   unused_data;

  assign unused_data = ^{M68K_DATA[15:8], 1'b0};

  assign we_s    = we_sync[SYNC_STAGES-1];
  assign we_fall = we_prev & ~we_s;
  assign we_rise = ~we_prev & we_s;

  // Write strobe synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      we_sync <= '1;
      we_prev <= 1'b1;
    end else begin
      we_sync[0] <= nPORTWEL;
      for (int i = 1; i < SYNC_STAGES; i++) we_sync[i] <= we_sync[i-1];
      we_prev <= we_s;
    end
  end

  // Holding register: the latest falling edge wins, so only the last write commits.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold_addr <= '0;
      hold_data <= '0;
    end else if (we_fall) begin
      hold_addr <= M68K_ADDR;
      hold_data <= M68K_DATA[7:0];
    end
  end

  assign is_gsel     = (hold_addr == GSEL_ADDR);
  assign gsel_commit = we_rise & is_gsel;
  assign bank_commit = we_rise & ~is_gsel;

  // Unlock sequence state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_r <= IDLE;
    else       state_r <= state_n;
  end

  // Unlock next-state: 0x5A, 0xA5, then any value loads GSEL; stalls time out.
  always_comb begin
    state_n   = state_r;
    gsel_load = 1'b0;
    if (gsel_commit) begin
      case (state_r)
        IDLE:    state_n = (hold_data == 8'h5A) ? K1 : IDLE;
        K1:      state_n = (hold_data == 8'hA5) ? K2 : IDLE;
        K2: begin
          state_n   = IDLE;
          gsel_load = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else if (state_r != IDLE && to_cnt >= TO_W'(UNLOCK_TO)) begin
      state_n = IDLE;
    end
  end

  // Clocks since the last commit while part-way through the unlock sequence.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                          to_cnt <= '0;
    else if (we_rise || state_r == IDLE) to_cnt <= '0;
    else if (to_cnt < TO_W'(UNLOCK_TO))  to_cnt <= to_cnt + 1'b1;
  end

  // GSEL load opens the settle window and resets the bank; other commits set the bank.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      GSEL     <= '0;
      P_BANK   <= '0;
      busy_cnt <= '0;
    end else if (gsel_load) begin
      GSEL     <= hold_data;
      P_BANK   <= '0;
      busy_cnt <= ST_W'(SETTLE);
    end else begin
      if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
      if (bank_commit)
        P_BANK <= (hold_data[BANK_W-1:0] <= banks_r) ? hold_data[BANK_W-1:0] : '0;
    end
  end

  assign BUSY = (busy_cnt != '0);

  // Game table values track the lookup except while the settle window is open.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ix_r    <= '0;
      banks_r <= '0;
    end else if (busy_cnt <= ST_W'(1)) begin
      ix_r    <= TBL_IX;
      banks_r <= TBL_BANKS;
    end
  end

  // Flash address: P1 reads use the base index, port reads add the bank offset.
  always_comb begin
    offset = nROMOE ? (IX_W'(P_BANK) + IX_W'(1)) : '0;
    sum    = ix_r + offset;
    csel   = sum[IX_W-1 -: CSEL_W];
    P_ADDR = {sum[HI_W-1:0], M68K_ADDR};
    P_nOE  = nROMOE & nPORTOEL & nPORTOEU;
  end

  // Chip enables: one-hot low on the selected chip, all high while settling.
  always_comb begin
    P_nCE = '1;
    for (int k = 0; k < CHIPS; k++)
      if (!BUSY && csel == CSEL_W'(k)) P_nCE[k] = 1'b0;
  end

endmodule

// File: tb/tb_prog_bank_ctrl.sv
// tb_prog_bank_ctrl: directed vectors with a scoreboard queue; the stimulus
// pushes expected values and a negedge monitor pops and compares them.
module tb_prog_bank_ctrl;

  localparam logic [18:0] GSEL_A = 19'h607F7;
  localparam int K_NCE = 0, K_ADDR = 1, K_GSEL = 2, K_BANK = 3, K_BUSY = 4, K_NOE = 5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [19:1] M68K_ADDR;
  logic [15:0] M68K_DATA;
  logic        nPORTWEL, nPORTOEL, nPORTOEU, nROMOE;
  logic [8:0]  TBL_IX;
  logic [2:0]  TBL_BANKS;
  logic [25:0] P_ADDR;
  logic [2:0]  P_nCE;
  logic        P_nOE;
  logic [7:0]  GSEL;
  logic [2:0]  P_BANK;
  logic        BUSY;

  typedef struct {
    int          kind;
    int          due;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  prog_bank_ctrl dut (
    .CLK(CLK), .RESET(RESET), .M68K_ADDR(M68K_ADDR), .M68K_DATA(M68K_DATA),
    .nPORTWEL(nPORTWEL), .nPORTOEL(nPORTOEL), .nPORTOEU(nPORTOEU), .nROMOE(nROMOE),
    .TBL_IX(TBL_IX), .TBL_BANKS(TBL_BANKS), .P_ADDR(P_ADDR), .P_nCE(P_nCE),
    .P_nOE(P_nOE), .GSEL(GSEL), .P_BANK(P_BANK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] actual_of(int kind);
    case (kind)
      K_NCE:   return {29'b0, P_nCE};
      K_ADDR:  return {6'b0, P_ADDR};
      K_GSEL:  return {24'b0, GSEL};
      K_BANK:  return {29'b0, P_BANK};
      K_BUSY:  return {31'b0, BUSY};
      default: return {31'b0, P_nOE};
    endcase
  endfunction

  function automatic string name_of(int kind);
    case (kind)
      K_NCE:   return "P_nCE";
      K_ADDR:  return "P_ADDR";
      K_GSEL:  return "GSEL";
      K_BANK:  return "P_BANK";
      K_BUSY:  return "BUSY";
      default: return "P_nOE";
    endcase
  endfunction

  // Monitor: compare every due expectation on the falling edge.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (actual_of(mon_e.kind) !== mon_e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                 name_of(mon_e.kind), actual_of(mon_e.kind), mon_e.exp, cyc);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(int kind, logic [31:0] exp);
    exp_t e;
    e.kind = kind;
    e.due  = cyc;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Port write: strobe low for four clocks, then wait 'post' clocks after release.
  task automatic applyStimulus(logic [18:0] addr, logic [15:0] data, int post);
    M68K_ADDR = addr;
    M68K_DATA = data;
    nPORTWEL  = 1'b0;
    tick(4);
    nPORTWEL  = 1'b1;
    if (post > 0) tick(post);
  endtask

  initial begin
    RESET = 1'b1; M68K_ADDR = '0; M68K_DATA = '0;
    nPORTWEL = 1'b1; nPORTOEL = 1'b1; nPORTOEU = 1'b1; nROMOE = 1'b0;
    TBL_IX = 9'h000; TBL_BANKS = 3'd3;
    tick(2);
    checkOutput(K_NCE, 3'b110); checkOutput(K_ADDR, 0); checkOutput(K_GSEL, 0);
    checkOutput(K_BANK, 0); checkOutput(K_BUSY, 0); checkOutput(K_NOE, 0);
    tick(1);
    RESET = 1'b0;
    tick(2);

    $display("[TB] bank writes");
    applyStimulus(19'h0, 16'h0002, 2);
    checkOutput(K_BANK, 0);
    tick(1);
    checkOutput(K_BANK, 2);
    tick(1);
    nROMOE = 1'b1; nPORTOEL = 1'b0; M68K_ADDR = 19'h10;
    checkOutput(K_ADDR, 32'h180010); checkOutput(K_NCE, 3'b110); checkOutput(K_NOE, 0);
    tick(1);
    nPORTOEL = 1'b1;
    checkOutput(K_NOE, 1);
    tick(1);
    nROMOE = 1'b0; M68K_ADDR = '0;
    applyStimulus(19'h0, 16'h0003, 3); checkOutput(K_BANK, 3);
    applyStimulus(19'h0, 16'h0005, 3); checkOutput(K_BANK, 0);
    applyStimulus(19'h0, 16'h0001, 3); checkOutput(K_BANK, 1);

    $display("[TB] unlock sequence");
    applyStimulus(GSEL_A, 16'h005A, 3); checkOutput(K_BANK, 1); checkOutput(K_GSEL, 0);
    applyStimulus(GSEL_A, 16'h00A5, 3); checkOutput(K_GSEL, 0); checkOutput(K_BUSY, 0);
    applyStimulus(GSEL_A, 16'h0012, 3);
    checkOutput(K_GSEL, 8'h12); checkOutput(K_BANK, 0);
    checkOutput(K_BUSY, 1); checkOutput(K_NCE, 3'b111);
    tick(3);
    checkOutput(K_BUSY, 1); checkOutput(K_NCE, 3'b111);
    tick(1);
    checkOutput(K_BUSY, 0); checkOutput(K_NCE, 3'b110);
    applyStimulus(GSEL_A, 16'h0034, 3); checkOutput(K_GSEL, 8'h12); checkOutput(K_BUSY, 0);

    $display("[TB] same-value reload");
    applyStimulus(19'h0, 16'h0002, 3); checkOutput(K_BANK, 2);
    applyStimulus(GSEL_A, 16'h005A, 3);
    applyStimulus(GSEL_A, 16'h00A5, 3);
    applyStimulus(GSEL_A, 16'h0012, 3);
    checkOutput(K_GSEL, 8'h12); checkOutput(K_BUSY, 1); checkOutput(K_BANK, 0);
    tick(4);
    checkOutput(K_BUSY, 0);

    $display("[TB] unlock timeout");
    applyStimulus(GSEL_A, 16'h005A, 3);
    tick(260);
    applyStimulus(GSEL_A, 16'h00A5, 3);
    applyStimulus(GSEL_A, 16'h0077, 3);
    checkOutput(K_GSEL, 8'h12); checkOutput(K_BUSY, 0);
    applyStimulus(GSEL_A, 16'h005A, 3);
    applyStimulus(GSEL_A, 16'h00A5, 3);
    applyStimulus(GSEL_A, 16'h0077, 3);
    checkOutput(K_GSEL, 8'h77); checkOutput(K_BUSY, 1);
    tick(4);

    $display("[TB] chip select decode");
    TBL_IX = 9'h180;
    tick(1);
    checkOutput(K_NCE, 3'b111);
    tick(1);
    TBL_IX = 9'h100;
    tick(1);
    checkOutput(K_NCE, 3'b011);
    tick(1);
    TBL_IX = 9'h1FF;
    tick(1);
    checkOutput(K_NCE, 3'b111);
    tick(1);
    nROMOE = 1'b1; nPORTOEL = 1'b0; M68K_ADDR = 19'h3;
    checkOutput(K_NCE, 3'b110); checkOutput(K_ADDR, 3);
    tick(1);
    nROMOE = 1'b0; nPORTOEL = 1'b1; M68K_ADDR = '0; TBL_IX = 9'h000;
    tick(2);

    $display("[TB] reset abandons operations");
    applyStimulus(GSEL_A, 16'h005A, 3);
    applyStimulus(GSEL_A, 16'h00A5, 3);
    RESET = 1'b1;
    tick(1);
    checkOutput(K_GSEL, 0); checkOutput(K_BANK, 0);
    tick(1);
    RESET = 1'b0;
    tick(2);
    applyStimulus(GSEL_A, 16'h0012, 3); checkOutput(K_GSEL, 0); checkOutput(K_BUSY, 0);
    applyStimulus(19'h0, 16'h0001, 3); checkOutput(K_BANK, 1);
    M68K_ADDR = 19'h0; M68K_DATA = 16'h0002; nPORTWEL = 1'b0;
    tick(4);
    RESET = 1'b1;
    tick(1);
    nPORTWEL = 1'b1;
    tick(1);
    RESET = 1'b0;
    tick(6);
    checkOutput(K_BANK, 0);

    tick(2);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
